// File: rtl/if_instr_queue_pkg.sv
// rtl/if_instr_queue_pkg.sv - shared CPU defines: IF-ID entry type, exception codes
//
// Contents:
//   IQ_EXC_W_DEF  default width of the fetch exception code field
//   EXC_*         fetch-side exception code constants
//   iq_entry_t    one IF-ID queue entry at the default exception width
package if_instr_queue_pkg;

  localparam int IQ_EXC_W_DEF = 8;

  localparam logic [IQ_EXC_W_DEF-1:0] EXC_NONE = 8'h00;
  localparam logic [IQ_EXC_W_DEF-1:0] EXC_ADEL = 8'h04;  // address error on fetch
  localparam logic [IQ_EXC_W_DEF-1:0] EXC_IBE  = 8'h06;  // bus error on fetch
  localparam logic [IQ_EXC_W_DEF-1:0] EXC_TLBL = 8'h02;  // TLB miss on fetch

  typedef struct packed {
    logic [31:0]             instr;
    logic [31:0]             pc;
    logic [IQ_EXC_W_DEF-1:0] except_code;
    logic                    ptaken;
    logic [31:0]             ptarget;
  } iq_entry_t;

endpackage

// File: rtl/if_instr_queue.sv
// rtl/if_instr_queue.sv - instruction queue decoupling the fetch and decode stages
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   IQ_Flush            drop every entry (exception, mispredict); wins over push/pop
//   IF_Valid, IF_*      fetch-side entry offered this cycle
//   IQ_Full             queue cannot accept; fetch holds its output
//   ID_Wr               decode consumes the head entry this cycle
//   IQ_Valid, IQ_*      head entry, forced to zero (nop bubble) when empty
//   IQ_Count            registered occupancy
module if_instr_queue
  import if_instr_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EXC_W = IQ_EXC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IQ_Flush,
  input  logic                       IF_Valid,
  input  logic [31:0]                IF_Instr,
  input  logic [31:0]                IF_PC,
  input  logic [EXC_W-1:0]           IF_ExceptCode,
  input  logic                       IF_PTaken,
  input  logic [31:0]                IF_PTarget,
  output logic                       IQ_Full,
  input  logic                       ID_Wr,
  output logic                       IQ_Valid,
  output logic [31:0]                IQ_Instr,
  output logic [31:0]                IQ_PC,
  output logic [EXC_W-1:0]           IQ_ExceptCode,
  output logic                       IQ_PTaken,
  output logic [31:0]                IQ_PTarget,
  output logic [$clog2(DEPTH):0]     IQ_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Same layout as iq_entry_t, but sized by this instance's EXC_W.
  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [EXC_W-1:0] except_code;
    logic             ptaken;
    logic [31:0]      ptarget;
  } entry_t;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head_entry;
  logic             push;
  logic             pop;

  assign IQ_Count = count;
  assign IQ_Full  = (count == CNT_W'(DEPTH));
  assign IQ_Valid = (count != '0);

  // Full blocks the push even if the head is popped in the same cycle.
  assign push = IF_Valid && !IQ_Full && !IQ_Flush;
  assign pop  = ID_Wr && IQ_Valid && !IQ_Flush;

  assign wr_entry = '{instr:       IF_Instr,
                      pc:          IF_PC,
                      except_code: IF_ExceptCode,
                      ptaken:      IF_PTaken,
                      ptarget:     IF_PTarget};

  always_ff @(posedge clk) begin
    if (rst || IQ_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; stale contents never reach the outputs because
  // the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_entry;
  end

  assign head_entry = mem[head];

  always_comb begin
    IQ_Instr      = '0;
    IQ_PC         = '0;
    IQ_ExceptCode = '0;
    IQ_PTaken     = 1'b0;
    IQ_PTarget    = '0;
    if (IQ_Valid) begin
      IQ_Instr      = head_entry.instr;
      IQ_PC         = head_entry.pc;
      IQ_ExceptCode = head_entry.except_code;
      IQ_PTaken     = head_entry.ptaken;
      IQ_PTarget    = head_entry.ptarget;
    end
  end

endmodule

// File: doc/if_instr_queue.md
IF_INSTR_QUEUE -- requirements
Module: if_instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, at least 2.
REQ-002 The block SHALL have parameter EXC_W, default 8, giving the width of the fetch exception code field.
REQ-003 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IQ_Flush  in  1  discard all entries (exception, mispredict)
- IF_Valid  in  1  fetch stage offers an instruction
- IF_Instr  in  32  fetched instruction word
- IF_PC  in  32  instruction PC
- IF_ExceptCode  in  EXC_W  fetch-side exception code
- IF_PTaken  in  1  branch predictor taken flag
- IF_PTarget  in  32  predicted target
- IQ_Full  out  1  queue cannot accept; fetch holds its output
- ID_Wr  in  1  ID stage consumes the head entry this cycle
- IQ_Valid  out  1  head entry present
- IQ_Instr  out  32  head instruction
- IQ_PC  out  32  head PC
- IQ_ExceptCode  out  EXC_W  head exception code
- IQ_PTaken  out  1  head predicted taken
- IQ_PTarget  out  32  head predicted target
- IQ_Count  out  clog2(DEPTH)+1  occupancy

Function
REQ-004 Storage SHALL be DEPTH entries, each holding {Instr, PC, ExceptCode, PTaken, PTarget}.
REQ-005 Push SHALL occur on a rising clk edge iff IF_Valid && !IQ_Full && !IQ_Flush; the entry is written at the tail pointer, and the tail advances by 1.
REQ-006 Pop SHALL occur on a rising clk edge iff ID_Wr && IQ_Valid && !IQ_Flush; the head pointer advances by 1.
REQ-007 Head and tail pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-008 IQ_Count SHALL be registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-009 IQ_Full SHALL equal (IQ_Count == DEPTH).
IQ_Valid SHALL equal (IQ_Count != 0).
Both are combinational from IQ_Count only.
REQ-010 When full, a same-cycle pop SHALL NOT enable a push; IQ_Full blocks the push for that cycle.
REQ-011 When empty, there SHALL be no bypass: a pushed entry appears on the IQ_* outputs one cycle after the push edge (latency 1).
REQ-012 IQ_Instr, IQ_PC, IQ_ExceptCode, IQ_PTaken and IQ_PTarget SHALL be the head entry when IQ_Valid=1, and all-zero when IQ_Valid=0, so the ID stage sees a nop bubble.
REQ-013 Simultaneous push and pop at count 1 SHALL leave count at 1; the next head is the newly pushed entry.
REQ-014 IQ_Flush SHALL take priority over push and pop: the next edge sets head=tail=0 and count=0, and the same-cycle IF entry is dropped.
REQ-015 ID_Wr while the queue is empty SHALL be ignored, with no pointer or count change.
REQ-016 The ExceptCode, PTaken and PTarget fields SHALL pass through unmodified; the block does not interpret them.

Reset
REQ-017 On a clk edge with rst=1: head=0, tail=0, count=0, IQ_Valid=0, IQ_Full=0, and all IQ_* data outputs zero.
REQ-018 rst SHALL override IQ_Flush, push and pop in the same cycle.
REQ-019 Entry storage SHALL need no reset, because it is masked by REQ-012.
REQ-020 Reset asserted mid-stream SHALL lose all entries, with the first post-reset push treated as a push to an empty queue.

Structure
REQ-021 The per-entry packed struct, the EXC_W default and the exception code constants SHALL live in the shared CPU defines package; the IF-ID interface SHALL reuse that struct.
REQ-022 No sub-module is required.
REQ-023 Storage SHALL be a flip-flop array with a write enable, not a RAM macro.

Verification
REQ-024 Reset, then push PC 0xBFC00000 and 0xBFC00004 with ID_Wr=0 -> IQ_Count=2, IQ_PC=0xBFC00000, IQ_Full=0.
REQ-025 Push 5 entries with ID_Wr=0 and DEPTH=4 -> IQ_Full=1 after the 4th; the 5th is not accepted and IQ_Count stays 4.
REQ-026 When full, assert IF_Valid and ID_Wr together -> count goes to 3 and the new entry is not stored. Next cycle, push and pop together -> count stays 3 and the order is preserved.
REQ-027 Push 6 and pop 6 interleaved, so that wrap-around occurs -> IQ_PC sequence matches push order with no loss or duplication.
REQ-028 With count 3, assert IQ_Flush and IF_Valid together -> next cycle count=0, IQ_Valid=0, IQ_Instr=0, and the flushed-cycle entry is absent.
REQ-029 With an empty queue and ID_Wr=1, push PC 0x80000000 carrying ExceptCode 0x04 and PTaken=1 with PTarget 0x80000100 -> the entry is visible one cycle later with its fields intact, and the earlier ID_Wr caused no underflow.
